halo_receiver: RTL and testbench

Receive side of the PPU neighbor-exchange (halo) protocol. The block accepts (row, column, value) halo writes from up to eight neighbor tiles and buffers each neighbor stream in its own small FIFO. It drains the FIFOs round-robin into a single valid/ready accumulate stream towards the accumulator buffer, and reports when every neighbor has signalled exchange done and all received data has been handed off. It sits between the neighbor links and the accumulator buffer, mirroring the PPU's neighbor_output_* / exchange_done transmitter.

---
 rtl/halo_if.sv | 31 +++
 rtl/halo_receiver.sv | 161 ++++++++++++++++
 tb/tb_halo_receiver.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halo_if.sv
// Neighbor-link and accumulate-stream bundle of the halo receiver.
// The master side drives the neighbor writes and acc_ready; the slave side is the receiver.
interface halo_if #(
    parameter int RC_W           = 7,
    parameter int NEIGHBOR_COUNT = 8
);
    logic [7:0]      neighbor_input_value        [NEIGHBOR_COUNT];
    logic [RC_W-1:0] neighbor_input_row          [NEIGHBOR_COUNT];
    logic [RC_W-1:0] neighbor_input_column       [NEIGHBOR_COUNT];
    logic            neighbor_input_write_enable [NEIGHBOR_COUNT];
    logic            neighbor_exchange_done      [NEIGHBOR_COUNT];
    logic            neighbor_cts                [NEIGHBOR_COUNT];
    logic            acc_valid;
    logic            acc_ready;
    logic [RC_W-1:0] acc_row;
    logic [RC_W-1:0] acc_column;
    logic [7:0]      acc_value;
    logic [2:0]      acc_source;

    modport master (
        output neighbor_input_value, neighbor_input_row, neighbor_input_column,
               neighbor_input_write_enable, neighbor_exchange_done, acc_ready,
        input  neighbor_cts, acc_valid, acc_row, acc_column, acc_value, acc_source
    );

    modport slave (
        input  neighbor_input_value, neighbor_input_row, neighbor_input_column,
               neighbor_input_write_enable, neighbor_exchange_done, acc_ready,
        output neighbor_cts, acc_valid, acc_row, acc_column, acc_value, acc_source
    );
endinterface

// File: rtl/halo_receiver.sv
// Halo exchange receiver: per-neighbor FIFOs drained round-robin into one
// registered accumulate request, plus round-completion and overflow tracking.
module halo_receiver #(
    parameter int TILE_SIZE      = 128,
    parameter int NEIGHBOR_COUNT = 8,
    parameter int FIFO_DEPTH     = 4,
    localparam int RC_W          = $clog2(TILE_SIZE)
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    halo_if.slave hif,
    output logic  exchange_complete,
    output logic  overflow_error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 2 * RC_W + 8;

    logic [ENT_W-1:0]          mem_r       [NEIGHBOR_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r    [NEIGHBOR_COUNT];
    logic [PTR_W-1:0]          rd_ptr_r    [NEIGHBOR_COUNT];
    logic [OCC_W-1:0]          occ_r       [NEIGHBOR_COUNT];
    logic [OCC_W-1:0]          occ_next_s  [NEIGHBOR_COUNT];
    logic [ENT_W-1:0]          entry_in_s  [NEIGHBOR_COUNT];
    logic [NEIGHBOR_COUNT-1:0] cts_r;
    logic [NEIGHBOR_COUNT-1:0] done_seen_r;
    logic [NEIGHBOR_COUNT-1:0] done_next_s;
    logic [NEIGHBOR_COUNT-1:0] we_s;
    logic [NEIGHBOR_COUNT-1:0] done_in_s;
    logic [NEIGHBOR_COUNT-1:0] push_s;
    logic [NEIGHBOR_COUNT-1:0] pop_s;
    logic [NEIGHBOR_COUNT-1:0] nonempty_s;
    logic [2:0]                rr_ptr_r;
    logic [2:0]                sel_s;
    logic                      found_s;
    logic                      load_s;
    logic [ENT_W-1:0]          head_s;

    logic                      acc_valid_r;
    logic [RC_W-1:0]           acc_row_r;
    logic [RC_W-1:0]           acc_column_r;
    logic [7:0]                acc_value_r;
    logic [2:0]                acc_source_r;

    // Flatten link inputs; a write is only accepted while its link is clear to send
    always_comb begin
        we_s       = '0;
        done_in_s  = '0;
        push_s     = '0;
        nonempty_s = '0;
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            we_s[i]       = hif.neighbor_input_write_enable[i];
            done_in_s[i]  = hif.neighbor_exchange_done[i];
            entry_in_s[i] = {hif.neighbor_input_row[i], hif.neighbor_input_column[i],
                             hif.neighbor_input_value[i]};
            push_s[i]     = we_s[i] & cts_r[i];
            nonempty_s[i] = (occ_r[i] != '0);
        end
    end

    // Round-robin pick from rr_ptr, pop decode and next occupancy
    always_comb begin
        int idx;
        load_s  = !acc_valid_r || hif.acc_ready;
        found_s = 1'b0;
        sel_s   = 3'd0;
        idx     = 0;
        for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
            idx = (int'(rr_ptr_r) + k) % NEIGHBOR_COUNT;
            if (!found_s && nonempty_s[idx]) begin
                found_s = 1'b1;
                sel_s   = 3'(idx);
            end else begin
                found_s = found_s;
            end
        end
        pop_s = '0;
        if (load_s && found_s) begin
            pop_s[sel_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
        head_s = mem_r[sel_s][rd_ptr_r[sel_s]];
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            case ({push_s[i], pop_s[i]})
                2'b10:   occ_next_s[i] = occ_r[i] + OCC_W'(1);
                2'b01:   occ_next_s[i] = occ_r[i] - OCC_W'(1);
                default: occ_next_s[i] = occ_r[i];
            endcase
        end
        // A done pulse coinciding with start must still be recorded
        done_next_s = (done_seen_r & ~{NEIGHBOR_COUNT{start}}) | done_in_s;
    end

    // Per-link FIFO storage, pointers, occupancy and registered clear-to-send
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                occ_r[i]    <= '0;
            end
            cts_r <= '1;
        end else begin
            for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= entry_in_s[i];
                    wr_ptr_r[i]           <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                occ_r[i] <= occ_next_s[i];
                cts_r[i] <= (occ_next_s[i] < OCC_W'(FIFO_DEPTH));
            end
        end
    end

    // Output request register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_valid_r  <= 1'b0;
            acc_row_r    <= '0;
            acc_column_r <= '0;
            acc_value_r  <= 8'd0;
            acc_source_r <= 3'd0;
            rr_ptr_r     <= 3'd0;
        end else if (load_s) begin
            acc_valid_r <= found_s;
            if (found_s) begin
                {acc_row_r, acc_column_r, acc_value_r} <= head_s;
                acc_source_r <= sel_s;
                rr_ptr_r     <= (sel_s == 3'(NEIGHBOR_COUNT - 1)) ? 3'd0 : sel_s + 3'd1;
            end
        end
    end

    // Round bookkeeping: done flags, completion and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            done_seen_r       <= '0;
            exchange_complete <= 1'b0;
            overflow_error    <= 1'b0;
        end else begin
            done_seen_r       <= done_next_s;
            exchange_complete <= (&done_next_s) && !(|nonempty_s) && !acc_valid_r && !(|we_s);
            overflow_error    <= overflow_error | (|(we_s & ~cts_r));
        end
    end

    assign hif.acc_valid  = acc_valid_r;
    assign hif.acc_row    = acc_row_r;
    assign hif.acc_column = acc_column_r;
    assign hif.acc_value  = acc_value_r;
    assign hif.acc_source = acc_source_r;

    for (genvar g = 0; g < NEIGHBOR_COUNT; g++) begin : g_cts
        assign hif.neighbor_cts[g] = cts_r[g];
    end
endmodule

// File: tb/tb_halo_receiver.sv
// Bench for halo_receiver: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_halo_receiver;
    localparam int N    = 8;
    localparam int RC_W = 7;
    localparam int D    = 4;

    typedef struct {
        logic [RC_W-1:0] r;
        logic [RC_W-1:0] c;
        logic [7:0]      v;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic exchange_complete;
    logic overflow_error;

    halo_if #(.RC_W(RC_W), .NEIGHBOR_COUNT(N)) hif ();

    halo_receiver #(.TILE_SIZE(128), .NEIGHBOR_COUNT(N), .FIFO_DEPTH(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .hif              (hif.slave),
        .exchange_complete(exchange_complete),
        .overflow_error   (overflow_error)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    bit started    = 1'b0;

    // Reference model state
    ent_t       q [N][$];
    bit         m_valid;
    ent_t       m_ent;
    int         m_src;
    int         m_rr;
    bit [N-1:0] m_done;
    bit         m_ovf;
    bit         m_cmp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] dut_cts();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = hif.neighbor_cts[i];
        return v;
    endfunction

    task automatic model_step();
        int         sz[N];
        bit [N-1:0] we;
        bit [N-1:0] dn;
        bit         pre_valid;
        bit         empty_all;
        bit [N-1:0] done_new;
        bit         found;
        int         idx;
        ent_t       e;
        if (reset) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_valid = 1'b0; m_ent = '{r: '0, c: '0, v: '0}; m_src = 0; m_rr = 0;
            m_done = '0; m_ovf = 1'b0; m_cmp = 1'b0;
            return;
        end
        empty_all = 1'b1;
        for (int i = 0; i < N; i++) begin
            sz[i] = q[i].size();
            we[i] = hif.neighbor_input_write_enable[i];
            dn[i] = hif.neighbor_exchange_done[i];
            if (sz[i] != 0) empty_all = 1'b0;
        end
        pre_valid = m_valid;
        done_new  = (start ? '0 : m_done) | dn;
        if (!m_valid || hif.acc_ready) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!found && sz[idx] > 0) begin
                    found = 1'b1;
                    m_ent = q[idx].pop_front();
                    m_src = idx;
                    m_rr  = (idx + 1) % N;
                end
            end
            m_valid = found;
        end
        m_cmp = (&done_new) && empty_all && !pre_valid && (we == '0);
        for (int i = 0; i < N; i++) begin
            if (we[i]) begin
                if (sz[i] < D) begin
                    e.r = hif.neighbor_input_row[i];
                    e.c = hif.neighbor_input_column[i];
                    e.v = hif.neighbor_input_value[i];
                    q[i].push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_done = done_new;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            started = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        logic [N-1:0] exp_cts;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < N; i++) exp_cts[i] = (q[i].size() < D);
                chk("acc_valid", hif.acc_valid, m_valid);
                if (m_valid) begin
                    chk("acc_row", hif.acc_row, m_ent.r);
                    chk("acc_column", hif.acc_column, m_ent.c);
                    chk("acc_value", hif.acc_value, m_ent.v);
                    chk("acc_source", hif.acc_source, m_src);
                end
                chk("neighbor_cts", dut_cts(), exp_cts);
                chk("exchange_complete", exchange_complete, m_cmp);
                chk("overflow_error", overflow_error, m_ovf);
            end
        end
    end

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            hif.neighbor_input_value[i]        = 8'd0;
            hif.neighbor_input_row[i]          = '0;
            hif.neighbor_input_column[i]       = '0;
            hif.neighbor_input_write_enable[i] = 1'b0;
            hif.neighbor_exchange_done[i]      = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic wr(input int i, input int r, input int c, input int v);
        hif.neighbor_input_write_enable[i] = 1'b1;
        hif.neighbor_input_row[i]          = RC_W'(r);
        hif.neighbor_input_column[i]       = RC_W'(c);
        hif.neighbor_input_value[i]        = 8'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int srcs[$];
        int vals[$];
        bit quiet;
        clear_inputs();
        reset = 1'b1;
        hif.acc_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst acc_valid", hif.acc_valid, 32'd0);
        chk("rst cts", dut_cts(), 32'hFF);
        chk("rst payload", {hif.acc_row, hif.acc_column, hif.acc_value, hif.acc_source}, 32'd0);
        chk("rst complete", exchange_complete, 32'd0);
        reset = 1'b0;

        // Single write on link 3
        hif.acc_ready = 1'b1;
        wr(3, 5, 7, 8'h2A);
        @(negedge clk);
        clear_inputs();
        chk("single early", hif.acc_valid, 32'd0);
        @(negedge clk);
        chk("single valid", hif.acc_valid, 32'd1);
        chk("single row", hif.acc_row, 32'd5);
        chk("single col", hif.acc_column, 32'd7);
        chk("single value", hif.acc_value, 32'h2A);
        chk("single source", hif.acc_source, 32'd3);
        chk("single cts3", hif.neighbor_cts[3], 32'd1);
        @(negedge clk);
        chk("single drop", hif.acc_valid, 32'd0);

        // Fairness: every link writes two entries in the same two cycles
        do_reset();
        for (int i = 0; i < N; i++) wr(i, i, 0, i);
        @(negedge clk);
        for (int i = 0; i < N; i++) wr(i, i, 1, 8 + i);
        @(negedge clk);
        clear_inputs();
        for (int t = 0; t < 20; t++) begin
            if (hif.acc_valid) begin
                srcs.push_back(int'(hif.acc_source));
                vals.push_back(int'(hif.acc_value));
            end
            @(negedge clk);
        end
        chk("fair count", srcs.size(), 32'd16);
        for (int k = 0; k < srcs.size(); k++) begin
            chk("fair source", srcs[k], k % 8);
            chk("fair value", vals[k], k);
        end
        chk("fair overflow", overflow_error, 32'd0);

        // Backpressure on link 0: first entry preloads the output register
        do_reset();
        hif.acc_ready = 1'b0;
        for (int e = 0; e < 6; e++) begin
            wr(0, e, e, 8'h10 + e);
            @(negedge clk);
            if (e == 3) chk("bp cts before full", hif.neighbor_cts[0], 32'd1);
            if (e == 4) chk("bp cts full", hif.neighbor_cts[0], 32'd0);
            if (e == 4) chk("bp no overflow yet", overflow_error, 32'd0);
        end
        clear_inputs();
        chk("bp overflow", overflow_error, 32'd1);
        for (int t = 0; t < 3; t++) begin
            chk("bp stall valid", hif.acc_valid, 32'd1);
            chk("bp stall value", hif.acc_value, 32'h10);
            @(negedge clk);
        end
        hif.acc_ready = 1'b1;
        vals.delete();
        for (int t = 0; t < 10; t++) begin
            if (hif.acc_valid) vals.push_back(int'(hif.acc_value));
            @(negedge clk);
        end
        chk("bp count", vals.size(), 32'd5);
        for (int k = 0; k < vals.size(); k++) chk("bp value", vals[k], 8'h10 + k);

        // Completion: link 6's done coincides with its write
        do_reset();
        hif.acc_ready = 1'b1;
        for (int i = 0; i < N; i++) wr(i, 0, 0, i);
        hif.neighbor_exchange_done[6] = 1'b1;
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < N; i++) hif.neighbor_exchange_done[i] = (i != 6);
        @(negedge clk);
        clear_inputs();
        for (int k = 1; k <= 10; k++) begin
            chk("cmp valid", hif.acc_valid, (k <= 8) ? 32'd1 : 32'd0);
            if (k <= 8) chk("cmp source", hif.acc_source, k - 1);
            chk("cmp complete", exchange_complete, (k == 10) ? 32'd1 : 32'd0);
            if (k < 10) @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cmp cleared by start", exchange_complete, 32'd0);

        // Reset mid-round with data buffered and a request pending
        hif.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(i, i, i, 8'h40 + i);
        @(negedge clk);
        for (int i = 0; i < 4; i++) wr(i, i, i, 8'h50 + i);
        @(negedge clk);
        clear_inputs();
        chk("mid valid", hif.acc_valid, 32'd1);
        do_reset();
        chk("mid rst valid", hif.acc_valid, 32'd0);
        chk("mid rst cts", dut_cts(), 32'hFF);
        chk("mid rst payload", {hif.acc_row, hif.acc_column, hif.acc_value, hif.acc_source}, 32'd0);
        chk("mid rst overflow", overflow_error, 32'd0);
        hif.acc_ready = 1'b1;
        wr(5, 1, 2, 8'h55);
        @(negedge clk);
        clear_inputs();
        chk("mid early", hif.acc_valid, 32'd0);
        @(negedge clk);
        chk("mid valid after", hif.acc_valid, 32'd1);
        chk("mid source", hif.acc_source, 32'd5);
        chk("mid value", hif.acc_value, 32'h55);

        // Randomized traffic with quiet windows so rounds can complete
        for (int c = 0; c < 4000; c++) begin
            quiet = (c % 250) >= 200;
            for (int i = 0; i < N; i++) begin
                hif.neighbor_input_write_enable[i] = !quiet && ($urandom_range(0, 99) < 30);
                hif.neighbor_input_row[i]          = RC_W'($urandom_range(0, 127));
                hif.neighbor_input_column[i]       = RC_W'($urandom_range(0, 127));
                hif.neighbor_input_value[i]        = 8'($urandom_range(0, 255));
                hif.neighbor_exchange_done[i]      = ($urandom_range(0, 99) < (quiet ? 10 : 2));
            end
            start         = ((c % 250) == 0) || (!quiet && $urandom_range(0, 99) < 1);
            hif.acc_ready = quiet ? 1'b1 : ($urandom_range(0, 99) < 65);
            reset         = ((c % 1000) == 999);
            @(negedge clk);
        end
        clear_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
